// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit multiplexed seven-segment scan driver:
// digit count, scan FSM states and the hex-to-segment table.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  // Patterns are gfedcba, active high.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment pattern decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with double-buffered digit
// registers, per-slot blanking and optional leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       lz_en,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [3:0] dig_en,
  output logic       frame_tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PHASE_SHOW = PW'(BLANK_CYCLES);

  logic [PW-1:0]         phase, phase_n;
  logic [1:0]            idx, idx_n;
  state_e                state, state_n;
  logic [3:0]            shadow_data [NUM_DIGITS];
  logic [3:0]            active_data [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_dp, active_dp;
  logic [3:0]            cur_nib;
  logic [6:0]            cur_seg;
  logic                  zero_above, suppress, frame_n;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [3:0]            dig_n;

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // Outputs are registered, so everything below describes the cycle after
  // the next edge: position, FSM state and the pixels it shows.
  always_comb begin
    phase_n = (phase == PHASE_LAST) ? '0 : phase + PW'(1);
    idx_n   = (phase == PHASE_LAST) ? idx + 2'd1 : idx;

    state_n = state;
    case (state)
      BLANK: if (phase_n == PHASE_SHOW) state_n = SHOW;
      SHOW:  if (phase_n == '0) state_n = BLANK;
      default: state_n = BLANK;
    endcase

    frame_n = (idx_n == 2'd3) && (phase_n == PHASE_LAST);
    cur_nib = active_data[idx_n];

    // A digit is blanked when it and every digit to its left are zero.
    zero_above = lz_en;
    suppress   = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (active_data[i] == 4'd0);
      if (zero_above && (idx_n == 2'(i))) suppress = 1'b1;
    end

    seg_n = '0;
    dp_n  = 1'b0;
    dig_n = '0;
    if (state_n == SHOW) begin
      dig_n = 4'b0001 << idx_n;
      seg_n = suppress ? 7'd0 : cur_seg;
      dp_n  = active_dp[idx_n];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase      <= '0;
      idx        <= '0;
      state      <= BLANK;
      seg_out    <= '0;
      dp_out     <= 1'b0;
      dig_en     <= '0;
      frame_tick <= 1'b0;
      wr_ready   <= 1'b0;
      shadow_dp  <= '0;
      active_dp  <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_data[i] <= '0;
        active_data[i] <= '0;
      end
    end else begin
      phase      <= phase_n;
      idx        <= idx_n;
      state      <= state_n;
      seg_out    <= seg_n;
      dp_out     <= dp_n;
      dig_en     <= dig_n;
      frame_tick <= frame_n;
      wr_ready   <= !frame_n;
      // wr_ready is low in the frame_tick cycle, so copy and write never collide.
      if (frame_tick) begin
        active_dp <= shadow_dp;
        for (int i = 0; i < NUM_DIGITS; i++) active_data[i] <= shadow_data[i];
      end
      if (wr_valid && wr_ready) begin
        shadow_data[wr_addr] <= wr_data;
        shadow_dp[wr_addr]   <= wr_dp;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (CLK_DIV=8, BLANK_CYCLES=2): directed scenarios
// plus random writes, checked every cycle against a frame-level model.
module tb_seg7_scan_driver;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       wr_dp = 1'b0;
  logic       lz_en = 1'b0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] dig_en;
  logic       frame_tick;

  seg7_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .lz_en      (lz_en),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .dig_en     (dig_en),
    .frame_tick (frame_tick)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog k=%0d observed=timeout expected=finish", k);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int         n_checks = 0;
  int         n_pass = 0;
  int         k = 0;
  logic [3:0] sh_val [4];
  logic [3:0] act_val [4];
  logic       sh_dp [4];
  logic       act_dp [4];
  logic       lz_prev;
  logic [6:0] seg_ref [16];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
  endtask

  task automatic model_reset();
    k = 0;
    lz_prev = 1'b0;
    for (int d = 0; d < 4; d++) begin
      sh_val[d] = '0; act_val[d] = '0; sh_dp[d] = 1'b0; act_dp[d] = 1'b0;
    end
    exp_q.delete();
    exp_q.push_back(32'(FRAME - 1));
  endtask

  task automatic check_outputs();
    int   slot, ph;
    bit   show, supp;
    logic [31:0] e;
    slot = (k / CLK_DIV) % 4;
    ph   = k % CLK_DIV;
    show = (ph >= BLANK);
    supp = lz_prev && (slot != 0);
    for (int d = slot; d < 4; d++) if (act_val[d] != 4'd0) supp = 1'b0;
    check("dig_en", 32'(dig_en), show ? 32'(4'b0001 << slot) : 32'd0);
    check("seg_out", 32'(seg_out), (show && !supp) ? 32'(seg_ref[act_val[slot]]) : 32'd0);
    check("dp_out", 32'(dp_out), show ? 32'(act_dp[slot]) : 32'd0);
    check("frame_tick", 32'(frame_tick), 32'((k % FRAME) == FRAME - 1));
    if (k > 0) check("wr_ready", 32'(wr_ready), 32'((k % FRAME) != FRAME - 1));
    if (frame_tick === 1'b1) begin
      if (exp_q.size() == 0) check("ft_queue", 32'(k), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("ft_cycle", 32'(k), e);
        exp_q.push_back(e + 32'(FRAME));
      end
    end
  endtask

  // Check this cycle, fold this cycle's inputs into the model, advance.
  task automatic cycle();
    check_outputs();
    if (wr_valid && ((k % FRAME) != FRAME - 1)) begin
      sh_val[wr_addr] = wr_data;
      sh_dp[wr_addr]  = wr_dp;
    end
    if ((k % FRAME) == FRAME - 1) begin
      for (int d = 0; d < 4; d++) begin
        act_val[d] = sh_val[d]; act_dp[d] = sh_dp[d];
      end
    end
    lz_prev = lz_en;
    @(posedge clk); #1;
    k++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_to(input int target);
    wr_valid = 1'b0;
    for (int t = 0; t < 1000 && k < target; t++) cycle();
  endtask

  task automatic write_digit(input logic [1:0] a, input logic [3:0] v, input logic p);
    bit acc;
    wr_valid = 1'b1; wr_addr = a; wr_data = v; wr_dp = p;
    for (int t = 0; t < 4; t++) begin
      acc = ((k % FRAME) != FRAME - 1);
      cycle();
      if (acc) break;
    end
    wr_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_dig"}, 32'(dig_en), 32'd0);
    check({tag, "_seg"}, 32'(seg_out), 32'd0);
    check({tag, "_dp"}, 32'(dp_out), 32'd0);
    check({tag, "_ft"}, 32'(frame_tick), 32'd0);
    check({tag, "_rdy"}, 32'(wr_ready), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    seg_ref = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reset held for two edges.
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check_zero_outputs("reset");
    end
    rst_n = 1'b1;
    model_reset();

    // Idle scan, then two writes landing in the next frame.
    idle_to(5);
    write_digit(2'd0, 4'h8, 1'b1);
    write_digit(2'd3, 4'hA, 1'b0);
    idle_to(30);
    write_digit(2'd2, 4'h4, 1'b1);
    // Request held across the frame_tick cycle: refused at 31, taken at 32.
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 4'hC; wr_dp = 1'b1;
    cycle();
    cycle();
    wr_valid = 1'b0;
    idle_to(34);
    check("f1_slot0_seg", 32'(seg_out), 32'h7F);
    check("f1_slot0_dp", 32'(dp_out), 32'd1);
    idle_to(42);
    check("f1_slot1_old", 32'(seg_out), 32'h3F);
    idle_to(50);
    check("f1_slot2_seg", 32'(seg_out), 32'h66);
    idle_to(58);
    check("f1_slot3_seg", 32'(seg_out), 32'h77);
    check("f1_slot3_dig", 32'(dig_en), 32'h8);
    idle_to(74);
    check("f2_slot1_new", 32'(seg_out), 32'h39);
    idle_to(128);

    // Random writes with zero-heavy data and occasional lz_en flips.
    for (int t = 0; t < 192; t++) begin
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr  = 2'($urandom_range(0, 3));
      wr_data  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      wr_dp    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      cycle();
    end
    wr_valid = 1'b0;

    // Leading-zero suppression with digits 3..0 = 0,0,5,0.
    lz_en = 1'b1;
    write_digit(2'd3, 4'h0, 1'b0);
    write_digit(2'd2, 4'h0, 1'b1);
    write_digit(2'd1, 4'h5, 1'b0);
    write_digit(2'd0, 4'h0, 1'b0);
    idle_to(((k / FRAME) + 2) * FRAME);
    idle_to(k + 2);
    check("lz_slot0", 32'(seg_out), 32'h3F);
    idle_to(k + CLK_DIV);
    check("lz_slot1", 32'(seg_out), 32'h6D);
    idle_to(k + CLK_DIV);
    check("lz_slot2_seg", 32'(seg_out), 32'h00);
    check("lz_slot2_dig", 32'(dig_en), 32'h4);
    check("lz_slot2_dp", 32'(dp_out), 32'd1);
    idle_to(k + CLK_DIV);
    check("lz_slot3_seg", 32'(seg_out), 32'h00);
    check("lz_slot3_dig", 32'(dig_en), 32'h8);

    // Reset mid-scan during a slot-2 SHOW cycle.
    lz_en = 1'b0;
    for (int t = 0; t < FRAME && (k % FRAME) != 19; t++) cycle();
    check_outputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_zero_outputs("midreset");
    rst_n = 1'b1;
    model_reset();
    idle_to(2);
    check("post_reset_dig", 32'(dig_en), 32'h1);
    check("post_reset_seg", 32'(seg_out), 32'h3F);
    idle_to(70);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
